// File: rtl/cmp_pipe_pkg.sv
// Shared types for the pipelined comparator and its combinational core.
package cmp_pipe_pkg;
  localparam int STAT_WIDTH = 16;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

  typedef struct packed {
    logic lt;
    logic ge;
    logic eq;
  } cmp_flags_t;
endpackage

// File: rtl/cmp_pipe_if.sv
// Operand/result handshake bundle for cmp_pipe_unit.
interface cmp_pipe_if #(
  parameter int DATA_WIDTH = 20,
  parameter int TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  is_signed;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic                  lt;
  logic                  ge;
  logic                  eq;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, a, b, is_signed, in_tag, out_ready,
    input  in_ready, out_valid, lt, ge, eq, out_tag
  );

  modport slave (
    input  in_valid, a, b, is_signed, in_tag, out_ready,
    output in_ready, out_valid, lt, ge, eq, out_tag
  );
endinterface

// File: rtl/cmp_core.sv
// Combinational lt/ge/eq compare; signed mode biases both MSBs so one
// unsigned magnitude compare serves both modes.
module cmp_core
  import cmp_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 20
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  cmp_mode_e             mode,
  output cmp_flags_t            flags
);
  logic [DATA_WIDTH-1:0] msb_flip;
  logic [DATA_WIDTH-1:0] ax;
  logic [DATA_WIDTH-1:0] bx;
  logic                  lt_w;

  always_comb begin
    msb_flip                 = '0;
    msb_flip[DATA_WIDTH-1]   = (mode == CMP_SIGNED);
    ax                       = a ^ msb_flip;
    bx                       = b ^ msb_flip;
    lt_w                     = (ax < bx);
    flags.lt                 = lt_w;
    flags.ge                 = !lt_w;
    flags.eq                 = (a == b);
  end
endmodule

// File: rtl/cmp_pipe_unit.sv
// Fixed-latency pipelined comparator with valid/ready backpressure.
// Optional CMP_PIPE_STATS_EN adds saturating handshake counters.
module cmp_pipe_unit
  import cmp_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cmp_pipe_if.slave             bus
`ifdef CMP_PIPE_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [STAT_WIDTH-1:0] stat_total,
  output logic [STAT_WIDTH-1:0] stat_lt
`endif
);
  logic                  adv;
  logic [STAGES:1]       vld_pipe;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  cmp_mode_e             mode_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  cmp_flags_t            s1_flags;
  cmp_flags_t            flg_tail;
  logic [TAG_WIDTH-1:0]  tag_tail;

  // Whole pipe moves in lockstep; bubbles are held, never collapsed.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= CMP_UNSIGNED;
      tag_q    <= '0;
    end else if (adv) begin
      vld_pipe[1] <= bus.in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (bus.in_valid) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        mode_q <= cmp_mode_e'(bus.is_signed);
        tag_q  <= bus.in_tag;
      end
    end
  end

  cmp_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a     (a_q),
    .b     (b_q),
    .mode  (mode_q),
    .flags (s1_flags)
  );

  generate
    if (STAGES == 1) begin : g_direct
      assign flg_tail = s1_flags;
      assign tag_tail = tag_q;
    end else begin : g_shift
      cmp_flags_t [STAGES-1:1]                flg_sr;
      logic       [STAGES-1:1][TAG_WIDTH-1:0] tag_sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          flg_sr <= '0;
          tag_sr <= '0;
        end else if (adv) begin
          flg_sr[1] <= s1_flags;
          tag_sr[1] <= tag_q;
          for (int i = 2; i < STAGES; i++) begin
            flg_sr[i] <= flg_sr[i-1];
            tag_sr[i] <= tag_sr[i-1];
          end
        end
      end

      assign flg_tail = flg_sr[STAGES-1];
      assign tag_tail = tag_sr[STAGES-1];
    end
  endgenerate

  // Flags are masked on bubbles so they read 0 rather than stale data.
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.lt        = vld_pipe[STAGES] & flg_tail.lt;
  assign bus.ge        = vld_pipe[STAGES] & flg_tail.ge;
  assign bus.eq        = vld_pipe[STAGES] & flg_tail.eq;
  assign bus.out_tag   = tag_tail;

`ifdef CMP_PIPE_STATS_EN
  logic hs;
  assign hs = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stat_total <= '0;
      stat_lt    <= '0;
    end else if (hs) begin
      if (stat_total != '1)          stat_total <= stat_total + 16'd1;
      if (bus.lt && (stat_lt != '1)) stat_lt    <= stat_lt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Bench for cmp_pipe_unit: directed plan items plus random traffic scored
// against an arithmetic reference queue.
module tb_cmp_pipe_unit;
  localparam int DW     = 20;
  localparam int STAGES = 2;
  localparam int TW     = 4;

  typedef struct {
    logic [TW-1:0] tag;
    logic          lt;
    logic          eq;
    int            acc;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   total, passes, fails;
  int   cyc, last_stall, hs_cnt;
  logic last_acc;
  logic prev_hold;
  logic [TW+3:0] prev_out;

`ifdef CMP_PIPE_STATS_EN
  logic        stats_clr;
  logic [15:0] stat_total, stat_lt;
  int          m_tot, m_lt;
`endif

  cmp_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  cmp_pipe_unit #(.DATA_WIDTH(DW), .STAGES(STAGES), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CMP_PIPE_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .stat_total (stat_total),
    .stat_lt    (stat_lt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Reference: signed operands become true integers, then ordinary compare.
  function automatic logic model_lt(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic s);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[DW-1]) sa = sa - (longint'(1) << DW);
    if (s && b[DW-1]) sb = sb - (longint'(1) << DW);
    return sa < sb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic hs, acc, clr;
    exp_t e, n;
    @(negedge clk);
    hs  = bus.out_valid && bus.out_ready && !rst;
    acc = bus.in_valid && bus.in_ready && !rst;
    n.tag = bus.in_tag;
    n.lt  = model_lt(bus.a, bus.b, bus.is_signed);
    n.eq  = (bus.a == bus.b);
    check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
    check("known", $isunknown({bus.out_valid, bus.lt, bus.ge, bus.eq, bus.out_tag}), 0);
    if (prev_hold)
      check("stable", {bus.out_valid, bus.lt, bus.ge, bus.eq, bus.out_tag}, prev_out);
    if (bus.out_valid) check("ge_inv", bus.ge, !bus.lt);
    if (bus.out_valid && !bus.out_ready) last_stall = cyc;
    if (hs) begin
      check("out_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q[0];
        check("out_tag", bus.out_tag, e.tag);
        check("lt", bus.lt, e.lt);
        check("eq", bus.eq, e.eq);
        if (last_stall < e.acc) check("latency", cyc - e.acc, STAGES - 1);
      end
    end
`ifdef CMP_PIPE_STATS_EN
    check("stat_total", stat_total, m_tot);
    check("stat_lt", stat_lt, m_lt);
    clr = stats_clr;
`else
    clr = 1'b0;
`endif
    prev_out  = {bus.out_valid, bus.lt, bus.ge, bus.eq, bus.out_tag};
    prev_hold = bus.out_valid && !bus.out_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      prev_hold = 1'b0;
`ifdef CMP_PIPE_STATS_EN
      m_tot = 0;
      m_lt  = 0;
`endif
    end else begin
      if (hs && q.size() > 0) begin
        e = q.pop_front();
        hs_cnt++;
`ifdef CMP_PIPE_STATS_EN
        if (!clr) begin
          if (m_tot < 16'hFFFF) m_tot++;
          if (e.lt && m_lt < 16'hFFFF) m_lt++;
        end
`endif
      end
      if (acc) begin
        n.acc = cyc;
        q.push_back(n);
      end
`ifdef CMP_PIPE_STATS_EN
      if (clr) begin
        m_tot = 0;
        m_lt  = 0;
      end
`endif
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                      input logic [TW-1:0] tag);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.in_tag    = tag;
    for (int k = 0; k < 50; k++) begin
      step();
      if (last_acc) break;
    end
    check("send_accepted", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0) break;
      step();
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int sent, hs0;
    logic [DW-1:0] corner[4];
    total = 0; passes = 0; fails = 0;
    cyc = 0; last_stall = -1; hs_cnt = 0; last_acc = 0; prev_hold = 0; prev_out = '0;
    corner[0] = 20'h80000; corner[1] = 20'h7FFFF; corner[2] = 20'h00000; corner[3] = 20'hFFFFF;
    rst = 1'b1;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.is_signed = 0; bus.in_tag = '0;
    bus.out_ready = 0;
`ifdef CMP_PIPE_STATS_EN
    stats_clr = 0; m_tot = 0; m_lt = 0;
`endif
    repeat (2) @(posedge clk);
    cyc = 2;
    #1 rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_flags", {bus.lt, bus.ge, bus.eq}, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // unsigned lt with fixed latency
    bus.out_ready = 1'b1;
    send(20'h0000F, 20'h00010, 1'b0, 4'd3);
    repeat (STAGES - 1) step();
    check("t1_valid", bus.out_valid, 1);
    check("t1_flags", {bus.lt, bus.ge, bus.eq}, 3'b100);
    check("t1_tag", bus.out_tag, 3);
    drain();

    // same operands, signed then unsigned, back-to-back
    send(20'h80000, 20'h00001, 1'b1, 4'd1);
    send(20'h80000, 20'h00001, 1'b0, 4'd2);
    repeat (STAGES - 1) step();
    check("t2_tag", bus.out_tag, 2);
    check("t2_flags", {bus.lt, bus.ge, bus.eq}, 3'b010);
    drain();

    // equality in both modes
    send(20'hABCDE, 20'hABCDE, 1'b1, 4'd4);
    send(20'hABCDE, 20'hABCDE, 1'b0, 4'd5);
    drain();

    // backpressure: out_ready 1,0,0 repeating
    hs0 = hs_cnt; sent = 0;
    for (int k = 0; k < 80; k++) begin
      bus.in_valid  = (sent < 6);
      bus.a         = DW'($urandom);
      bus.b         = DW'($urandom);
      bus.is_signed = $urandom % 2;
      bus.in_tag    = TW'(sent);
      bus.out_ready = (k % 3 == 0);
      step();
      if (last_acc) sent++;
      if (sent == 6 && q.size() == 0) break;
    end
    bus.in_valid = 1'b0;
    check("bp_sent", sent, 6);
    check("bp_emitted", hs_cnt - hs0, 6);
    drain();

    // reset with two compares in flight
    hs0 = hs_cnt;
    bus.out_ready = 1'b0;
    send(20'h00001, 20'h00002, 1'b0, 4'd7);
    send(20'h00003, 20'h00002, 1'b0, 4'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_flags", {bus.lt, bus.ge, bus.eq}, 0);
    check("mrst_out_tag", bus.out_tag, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mrst_quiet", bus.out_valid, 0);
    end
    check("mrst_none_emitted", hs_cnt - hs0, 0);
    send(20'h00010, 20'h00005, 1'b1, 4'd9);
    drain();

    // random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.is_signed = $urandom % 2;
      bus.in_tag    = TW'($urandom);
      case ($urandom % 4)
        0: begin bus.a = DW'($urandom); bus.b = bus.a; end
        1: begin bus.a = corner[$urandom % 4]; bus.b = corner[$urandom % 4]; end
        default: begin bus.a = DW'($urandom); bus.b = DW'($urandom); end
      endcase
      step();
    end
    drain();

`ifdef CMP_PIPE_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    for (int k = 0; k < 3; k++) send(DW'(k), DW'(k + 5), 1'b0, TW'(k));
    for (int k = 0; k < 2; k++) send(DW'(k + 9), DW'(k), 1'b0, TW'(k));
    drain();
    step();
    check("st_total5", stat_total, 5);
    check("st_lt3", stat_lt, 3);
    bus.out_ready = 1'b0;
    send(20'h00001, 20'h00002, 1'b0, 4'd1);
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) break;
      step();
    end
    check("st_pending", bus.out_valid, 1);
    stats_clr     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    stats_clr = 1'b0;
    check("st_clr_total", stat_total, 0);
    check("st_clr_lt", stat_lt, 0);
    drain();
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
